// File: rtl/pkt_tx_injector_if.sv
// -----------------------------------------------------------------------------
// pkt_tx_injector_if : CPU command port and datapath egress bundle
// Rev 1.0
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface pkt_tx_injector_if #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
   logic [11:0]           cpu_addr;
   logic [63:0]           cpu_din;
   logic                  cpu_wen;
   logic [63:0]           cpu_dout;
   logic [DATA_WIDTH-1:0] out_data;
   logic [CTRL_WIDTH-1:0] out_ctrl;
   logic                  out_wr;
   logic                  out_rdy;
   logic                  busy;
   logic                  done;

   modport master (
      output cpu_addr, cpu_din, cpu_wen, out_rdy,
      input  cpu_dout, out_data, out_ctrl, out_wr, busy, done
   );

   modport slave (
      input  cpu_addr, cpu_din, cpu_wen, out_rdy,
      output cpu_dout, out_data, out_ctrl, out_wr, busy, done
   );
endinterface

`default_nettype wire

// File: rtl/pkt_tx_injector.sv
// -----------------------------------------------------------------------------
// pkt_tx_injector : CPU-loaded packet buffer replayed onto a datapath on GO
// Rev 1.0
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module pkt_tx_injector #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH / 8,
   parameter int ADDR_WIDTH = 8
) (
   input  wire logic         clk,
   input  wire logic         reset,
   pkt_tx_injector_if.slave  bus
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_PREFETCH = 2'd1;
   localparam logic [1:0] S_SEND     = 2'd2;
   localparam logic [1:0] S_FINISH   = 2'd3;

   logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
   logic [CTRL_WIDTH-1:0] ctrl_mem_q [DEPTH];

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH-1:0] len_q, len_d;
   logic [15:0]           pkt_cnt_q, pkt_cnt_d;
   logic                  done_q, done_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
   logic [63:0]           cpu_dout_q, cpu_dout_d;

   logic                  busy;
   logic                  out_wr;

   // Command decode
   logic                  reg_sel;
   logic [1:0]            cmd;
   logic [ADDR_WIDTH-1:0] idx;
   logic                  go, len_wr, clr_done, data_wr, ctrl_wr;
   logic                  last_fire;
   logic                  tx_load;
   logic [ADDR_WIDTH-1:0] tx_addr;
   logic                  unused_addr;

   assign reg_sel     = bus.cpu_addr[11];
   assign cmd         = bus.cpu_addr[10:9];
   assign idx         = bus.cpu_addr[ADDR_WIDTH-1:0];
   assign unused_addr = ^bus.cpu_addr;

   // Buffer and LEN are frozen while a packet is in flight
   assign go        = bus.cpu_wen &  reg_sel & (cmd == 2'b01) & ~busy;
   assign len_wr    = bus.cpu_wen &  reg_sel & (cmd == 2'b00) & ~busy;
   assign clr_done  = bus.cpu_wen &  reg_sel & (cmd == 2'b11);
   assign data_wr   = bus.cpu_wen & ~reg_sel & (cmd == 2'b00) & ~busy;
   assign ctrl_wr   = bus.cpu_wen & ~reg_sel & (cmd == 2'b01) & ~busy;
   assign last_fire = out_wr & (rd_ptr_q == len_q);

   always_ff @(posedge clk) begin
      if (data_wr) data_mem_q[idx] <= DATA_WIDTH'(bus.cpu_din);
      if (ctrl_wr) ctrl_mem_q[idx] <= CTRL_WIDTH'(bus.cpu_din[7:0]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         rd_ptr_q   <= '0;
         len_q      <= '0;
         pkt_cnt_q  <= '0;
         done_q     <= 1'b0;
         out_data_q <= '0;
         out_ctrl_q <= '0;
         cpu_dout_q <= '0;
      end else begin
         state_q    <= state_d;
         rd_ptr_q   <= rd_ptr_d;
         len_q      <= len_d;
         pkt_cnt_q  <= pkt_cnt_d;
         done_q     <= done_d;
         out_data_q <= out_data_d;
         out_ctrl_q <= out_ctrl_d;
         cpu_dout_q <= cpu_dout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (go) state_d = S_PREFETCH;
         S_PREFETCH: state_d = S_SEND;
         S_SEND:     if (last_fire) state_d = S_FINISH;
         S_FINISH:   state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state_q != S_IDLE);
      out_wr = (state_q == S_SEND) & bus.out_rdy;
   end

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      len_d      = len_q;
      pkt_cnt_d  = pkt_cnt_q;
      done_d     = done_q;
      out_data_d = out_data_q;
      out_ctrl_d = out_ctrl_q;
      cpu_dout_d = '0;

      if (len_wr) len_d = bus.cpu_din[ADDR_WIDTH-1:0];

      // Pointer parks on LEN after the final word so a full buffer never wraps
      if (go)                        rd_ptr_d = '0;
      else if (out_wr && !last_fire) rd_ptr_d = rd_ptr_q + 1'b1;

      // Output register is the buffer's synchronous read port
      tx_load = (state_q == S_PREFETCH) | (out_wr & ~last_fire);
      tx_addr = (state_q == S_PREFETCH) ? rd_ptr_q : rd_ptr_q + 1'b1;
      if (tx_load) begin
         out_data_d = data_mem_q[tx_addr];
         out_ctrl_d = ctrl_mem_q[tx_addr];
      end

      if (last_fire) pkt_cnt_d = pkt_cnt_q + 16'd1;

      // A set on the packet's completion beats a coincident CLR_DONE
      if (last_fire || state_q == S_FINISH) done_d = 1'b1;
      else if (go || clr_done)              done_d = 1'b0;

      if (!reg_sel) begin
         if (cmd == 2'b00)      cpu_dout_d = 64'(data_mem_q[idx]);
         else if (cmd == 2'b01) cpu_dout_d = 64'(ctrl_mem_q[idx]);
      end else if (cmd == 2'b10) begin
         cpu_dout_d = {busy, done_q, 14'b0, pkt_cnt_q, 16'(rd_ptr_q), 16'(len_q)};
      end
   end

   assign bus.cpu_dout = cpu_dout_q;
   assign bus.out_data = out_data_q;
   assign bus.out_ctrl = out_ctrl_q;
   assign bus.out_wr   = out_wr;
   assign bus.busy     = busy;
   assign bus.done     = done_q;

endmodule

`default_nettype wire
